// File: rtl/led_chaser_pkg.sv
// Shared encodings for the LED chaser: pattern modes, bounce direction
// and fill/drain phase.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'b00,
    MODE_ROT_R  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    PHASE_FILL  = 1'b0,
    PHASE_DRAIN = 1'b1
  } phase_e;

endpackage

// File: rtl/led_chaser_if.sv
// Control/status bundle of the LED chaser. The master side (system or
// bench) drives freeze, mode and divider; the slave side (the chaser)
// drives the LED pattern and the step/wrap pulses.
interface led_chaser_if #(
  parameter int WIDTH = 17,
  parameter int DIV_W = 8
);
  logic             frz;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] LED;
  logic             step;
  logic             wrap;

  modport master (
    output frz, mode, div,
    input  LED, step, wrap
  );

  modport slave (
    input  frz, mode, div,
    output LED, step, wrap
  );
endinterface

// File: rtl/led_chaser_tick_div.sv
// Step-rate prescaler: counts clocks and raises tick once every div+1
// enabled clocks. Comparing with >= lets a lowered div take effect on
// the very next clock instead of waiting for a counter wrap.
module tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = (r_cnt >= div);
  // clr wins over a coincident hit so a mode reload never also steps
  assign tick  = en & ~clr & w_hit;

  // Counter: cleared by reset or reload, held while disabled
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_hit ? '0 : r_cnt + CNT_ONE;
    end
  end
endmodule

// File: rtl/led_chaser.sv
// LED chaser top: four pattern modes (rotate left/right, bounce,
// fill/drain) advanced by a programmable prescaler tick, with freeze,
// mode-change reload and step/wrap pulses.
module led_chaser #(
  parameter int WIDTH = 17,
  parameter int DIV_W = 8
) (
  input logic         clk,
  input logic         rst,
  led_chaser_if.slave bus
);
  import led_chaser_pkg::*;

  localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_led;
  logic [1:0]       r_mode_q;
  dir_e             r_dir;
  phase_e           r_phase;
  logic             r_step;
  logic             r_wrap;

  logic             w_tick;
  logic             w_mode_chg;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_led_next;
  dir_e             w_dir_next;
  phase_e           w_phase_next;
  logic             w_wrap_next;

  assign w_mode_chg = (bus.mode != r_mode_q);

  tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (~bus.frz),
    .clr  (w_mode_chg),
    .div  (bus.div),
    .tick (w_tick)
  );

  // Seed loaded when the incoming mode differs from the registered one
  always_comb begin
    w_seed = LED_ONE;
    case (bus.mode)
      MODE_ROT_L:  w_seed = LED_ONE;
      MODE_ROT_R:  w_seed = LED_MSB;
      MODE_BOUNCE: w_seed = LED_ONE;
      MODE_FILL:   w_seed = '0;
      default:     w_seed = LED_ONE;
    endcase
  end

  // Next pattern, direction, phase and wrap flag for the active mode
  always_comb begin
    w_led_next   = r_led;
    w_dir_next   = r_dir;
    w_phase_next = r_phase;
    w_wrap_next  = 1'b0;
    case (r_mode_q)
      MODE_ROT_L: begin
        w_led_next  = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
        w_wrap_next = (w_led_next == LED_ONE);
      end
      MODE_ROT_R: begin
        w_led_next  = {r_led[0], r_led[WIDTH-1:1]};
        w_wrap_next = (w_led_next == LED_MSB);
      end
      MODE_BOUNCE: begin
        if (r_dir == DIR_UP) begin
          if (r_led[WIDTH-1]) begin
            w_led_next = r_led >> 1;
            w_dir_next = DIR_DOWN;
          end else begin
            w_led_next = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_led_next = r_led << 1;
            w_dir_next = DIR_UP;
          end else begin
            w_led_next = r_led >> 1;
          end
        end
        w_wrap_next = (w_led_next == LED_ONE);
      end
      MODE_FILL: begin
        if (r_phase == PHASE_FILL) begin
          w_led_next = {r_led[WIDTH-2:0], 1'b1};
          if (w_led_next == '1) begin
            w_phase_next = PHASE_DRAIN;
          end
        end else begin
          w_led_next = {r_led[WIDTH-2:0], 1'b0};
          if (w_led_next == '0) begin
            w_phase_next = PHASE_FILL;
            w_wrap_next  = 1'b1;
          end
        end
      end
      default: begin
        w_led_next = r_led;
      end
    endcase
  end

  // Pattern state: reset, then mode reload, then tick-driven advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led    <= LED_ONE;
      r_dir    <= DIR_UP;
      r_phase  <= PHASE_FILL;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      r_mode_q <= bus.mode;
    end else begin
      r_mode_q <= bus.mode;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      if (w_mode_chg) begin
        r_led   <= w_seed;
        r_dir   <= DIR_UP;
        r_phase <= PHASE_FILL;
      end else if (w_tick) begin
        r_led   <= w_led_next;
        r_dir   <= w_dir_next;
        r_phase <= w_phase_next;
        r_step  <= 1'b1;
        r_wrap  <= w_wrap_next;
      end
    end
  end

  assign bus.LED  = r_led;
  assign bus.step = r_step;
  assign bus.wrap = r_wrap;
endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter WIDTH, default 17: number of LEDs; legal range 2..64.
REQ-002 Parameter DIV_W, default 8: width of the step-rate divider input.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 frz  in  1  freeze; high holds the pattern and the prescaler.
REQ-006 mode  in  2  pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 fill/drain.
REQ-007 div  in  DIV_W  step period minus one, in clocks (0 means step every clock).
REQ-008 LED  out  WIDTH  registered LED pattern.
REQ-009 step  out  1  registered one-cycle pulse, high in the cycle LED takes a new value from a tick.
REQ-010 wrap  out  1  registered one-cycle pulse, high when a tick completes a full pattern period.

Function
REQ-011 The prescaler counter (DIV_W bits) SHALL raise tick when cnt >= div, then clear to 0; otherwise it increments; lowering div mid-count gives a tick on the next clock.
REQ-012 With frz=1 the counter, LED, direction and phase SHALL hold, and step and wrap SHALL be 0.
REQ-013 On a tick with frz=0, LED SHALL advance one position, and step SHALL be 1 for that cycle only.
REQ-014 Rotate-left: LED SHALL rotate by one place toward the MSB, with the MSB wrapping to bit 0. The seed is 1; wrap SHALL be asserted on the tick that produces LED == 1.
REQ-015 Rotate-right: LED SHALL rotate by one place toward the LSB. The seed is 1<<(WIDTH-1); wrap SHALL be asserted on the tick that produces that seed.
REQ-016 Bounce: a single dot moves up while dir=up and down while dir=down. A tick with the dot at the MSB and dir=up SHALL move the dot to MSB-1 and set dir=down; a tick with the dot at bit 0 and dir=down SHALL move it to bit 1 and set dir=up. The seed is 1 with dir=up. The period is 2*(WIDTH-1) ticks, and wrap SHALL be asserted on the tick that produces bit 0.
REQ-017 Fill/drain: in the fill phase each tick SHALL compute LED = (LED<<1)|1 until LED is all ones, then switch to the drain phase. In the drain phase each tick SHALL compute LED = LED<<1 until LED is zero, then switch back to the fill phase. The seed is 0 in the fill phase. The period is 2*WIDTH ticks, and wrap SHALL be asserted on the tick that produces all zeros.
REQ-018 mode SHALL be registered into mode_q each clock.
REQ-019 When mode != mode_q, the next clock edge SHALL load the new mode's seed, clear the counter, set dir=up and phase=fill, and hold step=wrap=0. This reload SHALL happen even while frz=1.
REQ-020 A mode change SHALL take priority over a coincident tick. No pattern value outside the seeds and legal sequences SHALL ever appear on LED.
REQ-021 With div=D and frz=0 held, the first step after reset release SHALL occur on the (D+1)th rising edge. Subsequent steps SHALL occur every D+1 clocks.
REQ-022 In rotate and bounce modes LED SHALL have exactly one bit set at all times.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL load LED = 1, cnt = 0, dir = up, phase = fill, step = 0, wrap = 0 and mode_q = mode.
REQ-024 rst SHALL override frz, ticks and mode changes.
REQ-025 Reset asserted mid-pattern or mid-freeze SHALL restore exactly the REQ-023 state on the next edge.
REQ-026 The REQ-023 reset value LED = 1 applies in every mode, including modes 01 and 11.
REQ-027 Modes 01 and 11 SHALL reach their own seeds only through the REQ-019 reload; after reset in mode 01 or 11, LED SHALL advance from 1 using that mode's step rule.

Structure
REQ-028 Package led_chaser_pkg SHALL hold the mode encoding constants MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE and MODE_FILL, plus the dir and phase encodings.
REQ-029 The prescaler SHALL be a sub-module tick_div (parameter DIV_W; ports clk, rst, en, clr, div, tick), instantiated once.
REQ-030 The pattern update logic SHALL reside in led_chaser as a single registered process.

Verification (WIDTH=4, DIV_W=4)
REQ-031 Reset, then mode=00, div=0, frz=0 -> LED 0001, 0010, 0100, 1000, 0001 on consecutive clocks; wrap high only with the second 0001.
REQ-032 mode=10, div=0 -> LED 0001, 0010, 0100, 1000, 0100, 0010, 0001; wrap high with the final 0001 (6 ticks after start).
REQ-033 mode=11, div=1 -> LED steps every 2 clocks through 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap high with the final 0000.
REQ-034 mode=00, div=0; hold frz=1 for 5 clocks at LED=0100 -> LED stays 0100 and step=0; after release the next value is 1000.
REQ-035 mode switched from 00 to 01 at LED=0010, with frz=1 -> next clock LED=1000, cnt=0, step=0; assert rst while frozen -> LED=0001.
REQ-036 div=5 at LED=0001, cnt=3, then div set to 1 -> tick on the next clock and LED=0010; thereafter steps every 2 clocks.
